// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO writes plus issue and retirement of MULT/MULTU to a 2-stage multiplier.
// Define HILO_MADD_MSUB_EN to make ops 1xx (MADD/MADDU/MSUB/MSUBU) accumulate into {hi,lo}.
module hilo_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        stall,
   output logic        mul_en,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_sign,
   input  logic        mul_data_ok,
   input  logic [63:0] mul_result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [2:0] OP_MTHI = 3'b010;
   localparam logic [2:0] OP_MTLO = 3'b011;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        sign_q, sign_d;
`ifdef HILO_MADD_MSUB_EN
   logic        acc_q, acc_d;
   logic        sub_q, sub_d;
`endif

   logic        mul_class;
   logic        dec_sign;
   logic        issue;
   logic [63:0] hilo_cur;
   logic [63:0] hilo_res;

   always_comb begin
`ifdef HILO_MADD_MSUB_EN
      mul_class = (op[2:1] == 2'b00) || op[2];
`else
      mul_class = (op[2:1] == 2'b00);
`endif
      // Signed for MULT (000), MADD (100) and MSUB (110).
      dec_sign = ~op[0] && (op != OP_MTHI);
      issue    = rst && op_valid && mul_class && !flush && (state_q == IDLE);
   end

   // The multiplier output is combinational on its operands, so they are held from the registers after issue.
   always_comb begin
      mul_en   = issue;
      mul_a    = issue ? rs_val   : a_q;
      mul_b    = issue ? rt_val   : b_q;
      mul_sign = issue ? dec_sign : sign_q;
      stall    = rst && (issue
                         || ((state_q == BUSY)  && !mul_data_ok)
                         || ((state_q == DRAIN) && op_valid));
   end

   always_comb begin
      hilo_cur = {hi_q, lo_q};
`ifdef HILO_MADD_MSUB_EN
      if (acc_q) begin
         hilo_res = sub_q ? (hilo_cur - mul_result) : (hilo_cur + mul_result);
      end else begin
         hilo_res = mul_result;
      end
`else
      hilo_res = mul_result;
`endif
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
`ifdef HILO_MADD_MSUB_EN
      acc_d   = acc_q;
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = BUSY;
               a_d     = rs_val;
               b_d     = rt_val;
               sign_d  = dec_sign;
`ifdef HILO_MADD_MSUB_EN
               acc_d   = op[2];
               sub_d   = op[1];
`endif
            end else if (op_valid && !flush) begin
               if (op == OP_MTHI) begin
                  hi_d = rs_val;
               end else if (op == OP_MTLO) begin
                  lo_d = rs_val;
               end
            end
         end
         BUSY: begin
            if (mul_data_ok) begin
               state_d = IDLE;
               if (!flush) begin
                  hi_d = hilo_res[63:32];
                  lo_d = hilo_res[31:0];
               end
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // The cancelled product still arrives; wait it out and drop it.
            if (mul_data_ok) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
`ifdef HILO_MADD_MSUB_EN
         acc_q   <= 1'b0;
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
`ifdef HILO_MADD_MSUB_EN
         acc_q   <= acc_d;
         sub_q   <= sub_d;
`endif
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a 2-stage multiplier model and a scoreboard of expected {hi,lo}.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        stall;
   logic        mul_en;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_sign;
   logic        mul_data_ok;
   logic [63:0] mul_result;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] hilo_m;

   always #5 clk = ~clk;

   hilo_unit dut (
      .clk         (clk),
      .rst         (rst),
      .op_valid    (op_valid),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .flush       (flush),
      .stall       (stall),
      .mul_en      (mul_en),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_sign    (mul_sign),
      .mul_data_ok (mul_data_ok),
      .mul_result  (mul_result),
      .hi          (hi),
      .lo          (lo)
   );

   // Multiplier model: result valid two cycles after mul_en, computed from the operands presented then.
   logic        v1, v2;
   logic [63:0] sa, sb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= mul_en;
         v2 <= v1;
      end
   end

   assign mul_data_ok = v2;

   always_comb begin
      sa         = mul_sign ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
      sb         = mul_sign ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
      mul_result = v2 ? (sa * sb) : 64'hDEAD_BEEF_0BAD_F00D;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_mul(input logic [2:0] o);
`ifdef HILO_MADD_MSUB_EN
      return (o[2:1] == 2'b00) || o[2];
`else
      return (o[2:1] == 2'b00);
`endif
   endfunction

   function automatic bit sign_of(input logic [2:0] o);
      return (o == 3'b000) || (o == 3'b100) || (o == 3'b110);
   endfunction

   function automatic logic [63:0] ref_hilo(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
      logic [63:0] p, xa, xb;
      xa = sign_of(o) ? {{32{a[31]}}, a} : {32'b0, a};
      xb = sign_of(o) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      case (o)
         3'b000, 3'b001: return p;
         3'b010:         return {a, cur[31:0]};
         3'b011:         return {cur[63:32], a};
         default: begin
`ifdef HILO_MADD_MSUB_EN
            return o[1] ? (cur - p) : (cur + p);
`else
            return cur;
`endif
         end
      endcase
   endfunction

   // Called just after a rising edge; holds the op until stall drops, then checks the retired {hi,lo}.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp_v;
      int          cyc, n_en, n_stall;
      bit          mc;
      mc    = is_mul(o);
      exp_v = ref_hilo(o, a, b, hilo_m);
      exp_q.push_back(exp_v);
      hilo_m   = exp_v;
      op_valid = 1'b1;
      op       = o;
      rs_val   = a;
      rt_val   = b;
      flush    = 1'b0;
      cyc      = 0;
      n_en     = 0;
      n_stall  = 0;
      forever begin
         #3;
         if (mul_en) n_en++;
         if (stall) n_stall++;
         if (mc) begin
            check_val("mul_a_hold", {32'b0, mul_a}, {32'b0, a});
            check_val("mul_b_hold", {32'b0, mul_b}, {32'b0, b});
            if (cyc == 0) check_val("mul_sign", {63'b0, mul_sign}, {63'b0, sign_of(o)});
         end
         if (!stall) break;
         if (cyc >= 20) begin
            check_val("stall_timeout", {63'b0, stall}, 64'd0);
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      check_val("mul_en_pulses", n_en, mc ? 1 : 0);
      check_val("stall_cycles", n_stall, mc ? 2 : 0);
      check_val("hilo", {hi, lo}, exp_q.pop_front());
      $display("txn op=%b rs=%h rt=%h stall_cycles=%0d hi=%h lo=%h", o, a, b, n_stall, hi, lo);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      op_valid = 1'b1;
      op       = 3'b000;
      rs_val   = 32'hA5A5_A5A5;
      rt_val   = 32'h5A5A_5A5A;
      flush    = 1'b0;
      hilo_m   = 64'd0;
      #1 rst = 1'b0;
      #1;
      check_val("rst_hi", {32'b0, hi}, 64'd0);
      check_val("rst_lo", {32'b0, lo}, 64'd0);
      check_val("rst_stall", {63'b0, stall}, 64'd0);
      check_val("rst_mul_en", {63'b0, mul_en}, 64'd0);
      check_val("rst_mul_a", {32'b0, mul_a}, 64'd0);
      check_val("rst_mul_b", {32'b0, mul_b}, 64'd0);
      check_val("rst_mul_sign", {63'b0, mul_sign}, 64'd0);
      op_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();

      do_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op(3'b010, 32'h1234_5678, 32'h0);
      do_op(3'b011, 32'hCAFE_F00D, 32'h0);

      // Flush in IDLE: neither a move nor a multiply may happen.
      op_valid = 1'b1;
      op       = 3'b010;
      rs_val   = 32'hDEAD_BEEF;
      flush    = 1'b1;
      #3;
      check_val("flush_idle_stall", {63'b0, stall}, 64'd0);
      op = 3'b000;
      #1;
      check_val("flush_idle_mul_en", {63'b0, mul_en}, 64'd0);
      op = 3'b010;
      tick();
      flush    = 1'b0;
      op_valid = 1'b0;
      check_val("flush_idle_hilo", {hi, lo}, hilo_m);
      tick();
      check_val("flush_idle_no_issue", {63'b0, mul_data_ok}, 64'd0);

      // Flush coinciding with mul_data_ok: straight back to IDLE, no write.
      op_valid = 1'b1;
      op       = 3'b000;
      rs_val   = 32'd7;
      rt_val   = 32'd9;
      tick();
      tick();
      flush = 1'b1;
      #3;
      check_val("flush_ok_stall", {63'b0, stall}, 64'd0);
      tick();
      flush    = 1'b0;
      op_valid = 1'b0;
      check_val("flush_ok_hilo", {hi, lo}, hilo_m);
      do_op(3'b011, 32'h0000_0055, 32'h0);

      // Flush while busy: DRAIN drops the first product, the next MULT waits.
      op_valid = 1'b1;
      op       = 3'b000;
      rs_val   = 32'h0000_1000;
      rt_val   = 32'h0000_0010;
      #3;
      check_val("drain_issue_en", {63'b0, mul_en}, 64'd1);
      tick();
      op_valid = 1'b0;
      flush    = 1'b1;
      #3;
      check_val("drain_busy_stall", {63'b0, stall}, 64'd1);
      tick();
      flush    = 1'b0;
      op_valid = 1'b1;
      rs_val   = 32'h0000_0007;
      rt_val   = 32'hFFFF_FFFF;
      #3;
      check_val("drain_stall", {63'b0, stall}, 64'd1);
      check_val("drain_mul_en", {63'b0, mul_en}, 64'd0);
      check_val("drain_mul_a", {32'b0, mul_a}, 64'h0000_1000);
      tick();
      check_val("drain_discard", {hi, lo}, hilo_m);
      do_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFF);

      // Accumulate ops (no-ops unless the feature is built in).
      do_op(3'b010, 32'h0, 32'h0);
      do_op(3'b011, 32'hFFFF_FFFF, 32'h0);
      do_op(3'b101, 32'h1, 32'h1);
      do_op(3'b110, 32'h2, 32'hFFFF_FFFD);
      do_op(3'b111, 32'h0000_0010, 32'h0000_0003);
      do_op(3'b100, 32'hFFFF_FFFF, 32'h0000_0005);

      // Reset in BUSY cycle 1 abandons the multiply.
      op_valid = 1'b1;
      op       = 3'b000;
      rs_val   = 32'd5;
      rt_val   = 32'd6;
      tick();
      rst = 1'b0;
      #1;
      check_val("busy_rst_hi", {32'b0, hi}, 64'd0);
      check_val("busy_rst_lo", {32'b0, lo}, 64'd0);
      check_val("busy_rst_stall", {63'b0, stall}, 64'd0);
      check_val("busy_rst_mul_en", {63'b0, mul_en}, 64'd0);
      hilo_m = 64'd0;
      tick();
      rst      = 1'b1;
      op_valid = 1'b0;
      tick();
      do_op(3'b000, 32'h8000_0000, 32'h8000_0000);
      check_val("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have no parameters; the only configuration is the macro in REQ-030.
REQ-002 SHALL have port `clk`, input, 1 bit: single clock, all state on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `op_valid`, input, 1 bit: EX-stage HI/LO request present.
REQ-005 SHALL have port `op`, input, 3 bits: 000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-006 SHALL have port `rs_val`, input, 32 bits: first operand, and the MTHI/MTLO data.
REQ-007 SHALL have port `rt_val`, input, 32 bits: second operand.
REQ-008 SHALL have port `flush`, input, 1 bit: cancel the current request or operation.
REQ-009 SHALL have port `stall`, output, 1 bit: hold the pipeline.
REQ-010 SHALL have multiplier-side outputs `mul_en` (1 bit), `mul_a` (32 bits), `mul_b` (32 bits) and `mul_sign` (1 bit), all driven to the 2-stage multiplier.
REQ-011 SHALL have multiplier-side inputs `mul_data_ok` (1 bit) and `mul_result` (64 bits); `mul_result` is valid only while `mul_data_ok`=1.
REQ-012 SHALL have outputs `hi` and `lo`, 32 bits each, registered, read directly by MFHI/MFLO.

Function
REQ-013 SHALL implement an FSM with three states:
  - IDLE to BUSY on issue;
  - BUSY to IDLE on `mul_data_ok`;
  - BUSY to DRAIN on `flush` with `mul_data_ok`=0;
  - DRAIN to IDLE on `mul_data_ok`.
REQ-014 A multiply-class op SHALL be MULT, MULTU, or the accumulate ops when enabled.
REQ-015 Issue SHALL be defined as state IDLE, `op_valid`=1, a multiply-class op, and `flush`=0.
REQ-016 On issue, `mul_en`=1 for exactly that cycle; it SHALL be 0 in all other cycles.
REQ-017 `mul_sign` SHALL be 1 for MULT, MADD and MSUB, and 0 otherwise.
REQ-018 In the issue cycle, `mul_a`, `mul_b` and `mul_sign` SHALL pass `rs_val`, `rt_val` and the decoded sign through combinationally; they are captured into operand registers at issue.
REQ-019 From issue through the `mul_data_ok` cycle, `mul_a`, `mul_b` and `mul_sign` SHALL hold the captured values, because the multiplier result depends combinationally on its operands.
REQ-020 `stall` SHALL be combinational:
  - 1 in the issue cycle;
  - 1 in BUSY while `mul_data_ok`=0;
  - 1 in DRAIN when `op_valid`=1;
  - 0 otherwise.
REQ-021 Multiply latency SHALL be: issue in cycle 0, `mul_data_ok` in cycle 2, and `stall`=0 in cycle 2.
REQ-022 For MULT/MULTU, `{hi,lo}` SHALL be loaded with `mul_result` at the end of the `mul_data_ok` cycle in BUSY.
REQ-023 MTHI/MTLO in IDLE with `flush`=0 SHALL write `rs_val` to `hi` or `lo` at the next edge, with no stall; the other register is unchanged.
REQ-024 Any op arriving in DRAIN SHALL stall and be taken only after the return to IDLE.
REQ-025 `flush` in IDLE SHALL suppress issue and any MTHI/MTLO write.
REQ-026 `flush` in BUSY during the `mul_data_ok` cycle SHALL go to IDLE with no HI/LO write.
REQ-027 In DRAIN, the `mul_result` SHALL be discarded and HI/LO SHALL be unchanged.
REQ-028 All HI/LO arithmetic SHALL be 64-bit modulo 2^64 with no overflow flag.

Reset
REQ-029 While `rst`=0, asynchronously:
  - state SHALL be IDLE;
  - `hi`, `lo` and the operand registers SHALL be 0;
  - `stall`, `mul_en`, `mul_a`, `mul_b` and `mul_sign` SHALL be 0;
  - any in-flight operation SHALL be abandoned with no HI/LO write.

Configuration
REQ-030 With `HILO_MADD_MSUB_EN` defined:
  - ops 1xx SHALL be multiply-class;
  - on completion, MADD/MADDU SHALL load `{hi,lo}` = `{hi,lo}` + `mul_result`;
  - MSUB/MSUBU SHALL load `{hi,lo}` = `{hi,lo}` − `mul_result`;
  - the old `{hi,lo}` SHALL be sampled at completion.
REQ-031 Without `HILO_MADD_MSUB_EN`, ops 1xx SHALL be no-ops: no issue, no stall, no HI/LO change.

Verification
REQ-032 MULT with `rs_val`=0xFFFFFFFE and `rt_val`=3 -> `stall`=1 in cycles 0–1, one `mul_en` pulse, then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA.
REQ-033 MULTU with `rs_val`=`rt_val`=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `mul_a`/`mul_b` stable for 3 cycles.
REQ-034 MTHI with `rs_val`=0x12345678 in IDLE -> `hi`=0x12345678 after 1 edge, `stall` never 1, `lo` unchanged.
REQ-035 MULT, then `flush` in cycle 1, then a new MULT in cycle 2:
  - DRAIN is entered and the first result is discarded;
  - the new op stalls and issues in cycle 3 with one `mul_en` pulse;
  - only the second product is written.
REQ-036 Accumulate op 101 (MADDU) with `hi`=0, `lo`=0xFFFFFFFF, `rs_val`=`rt_val`=1:
  - macro defined -> `hi`=1, `lo`=0;
  - macro undefined -> no stall and no change.
REQ-037 `rst` low in BUSY cycle 1 -> `hi`=`lo`=0 and `stall`=`mul_en`=0 immediately; after release, a MULT issues normally.
